// File: rtl/spinn_out_mapper.sv
// SpiNNaker-to-AER receive path: parity/type filter, key masking, event FIFO,
// and a dump mode that keeps the SpiNNaker link draining when the AER sink stalls.
module spinn_out_mapper #(
  parameter int AER_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 dump_mode,
  input  logic                 dump_on,
  input  logic                 dump_off,
  input  logic [31:0]          rx_data_mask,
  input  logic [71:0]          opkt_data,
  input  logic                 opkt_vld,
  output logic                 opkt_rdy,
  output logic [AER_WIDTH-1:0] oaer_data,
  output logic                 oaer_vld,
  input  logic                 oaer_rdy,
  output logic                 parity_err,
  output logic [15:0]          parity_err_cnt,
  output logic [15:0]          type_drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [AER_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 fifo_full, fifo_empty;

  logic                 cmd_dump, aer_timeout, live;
  logic [7:0]           to_cnt;

  logic                 accept, par_ok, is_mc, wr, rd, flush;
  logic [AER_WIDTH-1:0] key;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // live holds opkt_rdy low while in reset and for the first edge after it
  assign opkt_rdy  = live & enable & (~fifo_full | dump_mode);
  assign oaer_vld  = enable & ~fifo_empty & ~dump_mode;
  assign oaer_data = mem[rd_ptr];

  // Short packets carry odd parity over 40 bits, payload packets over all 72
  assign par_ok = opkt_data[1] ? (^opkt_data) : (^opkt_data[39:0]);
  assign is_mc  = (opkt_data[7:6] == 2'b00);
  assign key    = opkt_data[8 +: AER_WIDTH] & rx_data_mask[AER_WIDTH-1:0];

  assign accept = opkt_vld & opkt_rdy;
  assign wr     = accept & par_ok & is_mc & ~dump_mode;
  assign rd     = oaer_vld & oaer_rdy;
  assign flush  = (cmd_dump | aer_timeout) & ~dump_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= key;
    end
  end

  // Entering dump drops everything queued; a same-edge write is lost too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= ptr_inc(wr_ptr);
      if (rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err     <= 1'b0;
      parity_err_cnt <= '0;
      type_drop_cnt  <= '0;
    end else begin
      parity_err <= accept & ~par_ok;
      if (accept & ~par_ok & (parity_err_cnt != 16'hFFFF))
        parity_err_cnt <= parity_err_cnt + 16'd1;
      if (accept & par_ok & ~is_mc & (type_drop_cnt != 16'hFFFF))
        type_drop_cnt <= type_drop_cnt + 16'd1;
    end
  end

  // aer_timeout drops on the same edge oaer_rdy returns, so dump clears one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_dump    <= 1'b1;
      to_cnt      <= 8'(TIMEOUT);
      aer_timeout <= 1'b0;
      dump_mode   <= 1'b1;
      live        <= 1'b0;
    end else begin
      live <= 1'b1;
      if (dump_off)     cmd_dump <= 1'b0;
      else if (dump_on) cmd_dump <= 1'b1;
      if (oaer_rdy)              to_cnt <= 8'(TIMEOUT);
      else if (to_cnt != 8'd0)   to_cnt <= to_cnt - 8'd1;
      aer_timeout <= (to_cnt == 8'd0) & ~oaer_rdy;
      dump_mode   <= cmd_dump | aer_timeout;
    end
  end

endmodule
